// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised FIFO: read-mode enum and default parameter values.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int FIFO_DEF_DATA_WIDTH = 16;
  localparam int FIFO_DEF_DEPTH      = 8;
  localparam int FIFO_DEF_AE_LEVEL   = 1;
  localparam int FIFO_DEF_FWFT       = 0;

  // Maps the integer FWFT parameter onto the read-mode enum.
  function automatic fifo_mode_e mode_from_param(input int fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the pushed word; contents are never cleared, occupancy tracking makes stale words invisible.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with status flags, sticky error flags and a selectable read mode.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = FIFO_DEF_AE_LEVEL,
  parameter int FWFT       = FIFO_DEF_FWFT,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam fifo_mode_e MODE = mode_from_param(FWFT);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  mem_we;

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_ok  = read_en && !empty;
  assign wr_ok  = write_en && (!full || rd_ok);
  assign mem_we = wr_ok && reset_n;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Pointers wrap naturally at DEPTH (power of two); count moves only when exactly one side is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  // Sticky error flags: a new error in the same cycle wins over clr_err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && !wr_ok) overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (read_en && !rd_ok)  underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head entry is shown directly; masked to zero while empty so stale memory never leaks out.
      assign data_out   = empty ? '0 : mem_rdata;
      assign data_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      // Registered read: capture the head on an accepted read and flag it valid for one cycle.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) data_q <= mem_rdata;
        end
      end

      assign data_out   = data_q;
      assign data_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench: a registered-read FIFO and an FWFT FIFO share one stimulus stream and are
// compared every cycle against a queue-based model, with literal spot checks on key scenarios.
module tb_param_fifo;

  logic        clk;
  logic        reset_n;
  logic        write_en;
  logic        read_en;
  logic [15:0] data_in;
  logic        clr_err;

  logic [15:0] s_data_out;
  logic        s_data_valid;
  logic [3:0]  s_count;
  logic        s_full, s_empty, s_almost_full, s_almost_empty, s_overflow, s_underflow;

  logic [15:0] f_data_out;
  logic        f_data_valid;
  logic [3:0]  f_count;
  logic        f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;

  int n_checks;
  int n_fails;

  param_fifo dut_s (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_en     (write_en),
    .read_en      (read_en),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (s_data_out),
    .data_valid   (s_data_valid),
    .count        (s_count),
    .full         (s_full),
    .empty        (s_empty),
    .almost_full  (s_almost_full),
    .almost_empty (s_almost_empty),
    .overflow     (s_overflow),
    .underflow    (s_underflow)
  );

  param_fifo #(
    .DATA_WIDTH (16),
    .DEPTH      (8),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2),
    .FWFT       (1)
  ) dut_f (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_en     (write_en),
    .read_en      (read_en),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (f_data_out),
    .data_valid   (f_data_valid),
    .count        (f_count),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_almost_full),
    .almost_empty (f_almost_empty),
    .overflow     (f_overflow),
    .underflow    (f_underflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state: the queue is the FIFO contents, head at index 0.
  logic [15:0] model_q[$];
  bit          m_ovf;
  bit          m_udf;
  bit          m_dv_s;
  logic [15:0] m_dout_s;
  bit          check_en;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge consume them, return 1 time unit after the edge.
  task automatic applyStimulus(input bit rst_n, input bit we, input bit re, input logic [15:0] din, input bit clr);
    reset_n  = rst_n;
    write_en = we;
    read_en  = re;
    data_in  = din;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  // Model update at each rising edge, from the queue-level rules of the FIFO.
  initial begin : model_proc
    bit rd_ok;
    bit wr_ok;
    check_en = 0;
    m_ovf    = 0;
    m_udf    = 0;
    m_dv_s   = 0;
    m_dout_s = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        model_q.delete();
        m_ovf    = 0;
        m_udf    = 0;
        m_dv_s   = 0;
        m_dout_s = '0;
        check_en = 1;
      end else begin
        rd_ok = read_en && (model_q.size() != 0);
        wr_ok = write_en && ((model_q.size() < 8) || rd_ok);
        m_dv_s = rd_ok;
        if (rd_ok) m_dout_s = model_q.pop_front();
        if (wr_ok) model_q.push_back(data_in);
        if (write_en && !wr_ok) m_ovf = 1;
        else if (clr_err)       m_ovf = 0;
        if (read_en && !rd_ok)  m_udf = 1;
        else if (clr_err)       m_udf = 0;
      end
    end
  end

  // Compare both DUTs against the model on every falling edge once reset has been seen.
  initial begin : compare_proc
    int sz;
    forever begin
      @(negedge clk);
      if (check_en) begin
        sz = model_q.size();
        checkOutput("s_count",        32'(s_count),        32'(sz));
        checkOutput("s_full",         32'(s_full),         32'(sz == 8));
        checkOutput("s_empty",        32'(s_empty),        32'(sz == 0));
        checkOutput("s_almost_full",  32'(s_almost_full),  32'(sz >= 7));
        checkOutput("s_almost_empty", 32'(s_almost_empty), 32'(sz <= 1));
        checkOutput("s_overflow",     32'(s_overflow),     32'(m_ovf));
        checkOutput("s_underflow",    32'(s_underflow),    32'(m_udf));
        checkOutput("s_data_valid",   32'(s_data_valid),   32'(m_dv_s));
        checkOutput("s_data_out",     32'(s_data_out),     32'(m_dout_s));
        checkOutput("f_count",        32'(f_count),        32'(sz));
        checkOutput("f_full",         32'(f_full),         32'(sz == 8));
        checkOutput("f_empty",        32'(f_empty),        32'(sz == 0));
        checkOutput("f_almost_full",  32'(f_almost_full),  32'(sz >= 6));
        checkOutput("f_almost_empty", 32'(f_almost_empty), 32'(sz <= 2));
        checkOutput("f_overflow",     32'(f_overflow),     32'(m_ovf));
        checkOutput("f_underflow",    32'(f_underflow),    32'(m_udf));
        checkOutput("f_data_valid",   32'(f_data_valid),   32'(sz != 0));
        checkOutput("f_data_out",     32'(f_data_out),     (sz != 0) ? 32'(model_q[0]) : 32'd0);
      end
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin : stim_proc
    int wp;
    int rp;
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    clr_err  = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 1, 16'hFFFF, 0);

    // Reset state.
    checkOutput("rst_count",        32'(s_count),        0);
    checkOutput("rst_empty",        32'(s_empty),        1);
    checkOutput("rst_full",         32'(s_full),         0);
    checkOutput("rst_almost_empty", 32'(s_almost_empty), 1);
    checkOutput("rst_almost_full",  32'(s_almost_full),  0);
    checkOutput("rst_data_out",     32'(s_data_out),     0);
    checkOutput("rst_f_data_valid", 32'(f_data_valid),   0);

    // Fill with 1..8.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 1, 0, 16'(k), 0);
      if (k == 1) begin
        checkOutput("fwft_first_data",  32'(f_data_out),   1);
        checkOutput("fwft_first_valid", 32'(f_data_valid), 1);
      end
      if (k == 5) checkOutput("f_af_at5", 32'(f_almost_full), 0);
      if (k == 6) begin
        checkOutput("s_af_at6", 32'(s_almost_full), 0);
        checkOutput("f_af_at6", 32'(f_almost_full), 1);
      end
      if (k == 7) checkOutput("s_af_at7", 32'(s_almost_full), 1);
    end
    checkOutput("fill_count",    32'(s_count),    8);
    checkOutput("fill_full",     32'(s_full),     1);
    checkOutput("fill_overflow", 32'(s_overflow), 0);

    // Overflow on a write while full, then clear.
    applyStimulus(1, 1, 0, 16'h0009, 0);
    checkOutput("ovf_set",   32'(s_overflow), 1);
    checkOutput("ovf_count", 32'(s_count),    8);
    checkOutput("ovf_head",  32'(f_data_out), 1);
    applyStimulus(1, 0, 0, 16'h0000, 1);
    checkOutput("ovf_clr",   32'(s_overflow), 0);

    // Drain: each read gives a one-cycle valid pulse with data in order.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 0, 1, 16'h0000, 0);
      checkOutput("drain_data",  32'(s_data_out),   32'(k));
      checkOutput("drain_valid", 32'(s_data_valid), 1);
      applyStimulus(1, 0, 0, 16'h0000, 0);
      checkOutput("drain_pulse_end", 32'(s_data_valid), 0);
      checkOutput("drain_hold",      32'(s_data_out),   32'(k));
    end
    applyStimulus(1, 0, 1, 16'h0000, 0);
    checkOutput("udf_set",   32'(s_underflow), 1);
    checkOutput("udf_count", 32'(s_count),     0);
    applyStimulus(1, 0, 0, 16'h0000, 1);
    checkOutput("udf_clr",   32'(s_underflow), 0);

    // Simultaneous read and write while full.
    for (int k = 0; k < 8; k++) applyStimulus(1, 1, 0, 16'(16'h0010 + k), 0);
    applyStimulus(1, 1, 1, 16'h00AA, 0);
    checkOutput("sim_full_data",  32'(s_data_out), 32'h10);
    checkOutput("sim_full_count", 32'(s_count),    8);
    checkOutput("sim_full_ovf",   32'(s_overflow), 0);
    checkOutput("sim_full_fhead", 32'(f_data_out), 32'h11);
    for (int k = 0; k < 8; k++) applyStimulus(1, 0, 1, 16'h0000, 0);
    checkOutput("sim_full_tail",  32'(s_data_out), 32'hAA);

    // Simultaneous read and write while empty, then alternating push/pop across the wrap.
    applyStimulus(1, 1, 1, 16'h0055, 0);
    checkOutput("sim_empty_udf",   32'(s_underflow),  1);
    checkOutput("sim_empty_count", 32'(s_count),      1);
    checkOutput("sim_empty_valid", 32'(s_data_valid), 0);
    applyStimulus(1, 0, 0, 16'h0000, 1);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) applyStimulus(1, 0, 1, 16'h0000, 0);
      else            applyStimulus(1, 1, 0, 16'(16'h0100 + i), 0);
      if (i == 0) checkOutput("wrap_first_pop", 32'(s_data_out), 32'h55);
    end
    applyStimulus(1, 0, 1, 16'h0000, 0);
    checkOutput("wrap_last_pop", 32'(s_data_out), 32'h113);

    // Randomized phase with shifting read/write bias and occasional reset.
    for (int i = 0; i < 900; i++) begin
      case ((i / 60) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      applyStimulus($urandom_range(199) != 0,
                    $urandom_range(99) < wp,
                    $urandom_range(99) < rp,
                    16'($urandom()),
                    $urandom_range(9) == 0);
    end

    // FWFT fall-through, almost_full at 6, reset mid-fill.
    applyStimulus(0, 0, 0, 16'h0000, 0);
    applyStimulus(1, 1, 0, 16'h1234, 0);
    checkOutput("fwft_1234_data",  32'(f_data_out),   32'h1234);
    checkOutput("fwft_1234_valid", 32'(f_data_valid), 1);
    for (int k = 2; k <= 6; k++) begin
      applyStimulus(1, 1, 0, 16'(k), 0);
      if (k == 5) checkOutput("fwft_af5", 32'(f_almost_full), 0);
      if (k == 6) checkOutput("fwft_af6", 32'(f_almost_full), 1);
    end
    checkOutput("fwft_head_kept", 32'(f_data_out), 32'h1234);
    applyStimulus(0, 1, 1, 16'hBEEF, 0);
    checkOutput("midrst_count", 32'(f_count),      0);
    checkOutput("midrst_empty", 32'(f_empty),      1);
    checkOutput("midrst_valid", 32'(f_data_valid), 0);
    checkOutput("midrst_s_cnt", 32'(s_count),      0);
    applyStimulus(1, 0, 0, 16'h0000, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of the data bus in bits.
REQ-002 Parameter: DEPTH, default 8, number of entries; power of two, at least 2.
REQ-003 Parameter: AF_LEVEL, default DEPTH-1, almost_full threshold; range 1..DEPTH.
REQ-004 Parameter: AE_LEVEL, default 1, almost_empty threshold; range 0..DEPTH-1.
REQ-005 Parameter: FWFT, default 0, read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-006 Derived constant: ADDR_WIDTH = clog2(DEPTH); it is not user-settable.
REQ-007 The block shall have one clock; reset is synchronous and active-low.
REQ-008 Ports, clock and reset first:
- clk  in  1  system clock, all logic on the rising edge
- reset_n  in  1  synchronous active-low reset
- write_en  in  1  push request
- read_en  in  1  pop request
- data_in  in  DATA_WIDTH  push data
- clr_err  in  1  clears the sticky error flags
- data_out  out  DATA_WIDTH  pop data
- data_valid  out  1  data_out holds valid data
- count  out  ADDR_WIDTH+1  current occupancy
- full, empty, almost_full, almost_empty  out  1 each  status flags
- overflow, underflow  out  1 each  sticky error flags

Function
REQ-009 Write acceptance: wr_ok = write_en && (!full || rd_ok); a write to a full FIFO is accepted only when a read is accepted in the same cycle.
REQ-010 Read acceptance: rd_ok = read_en && !empty; a read is never accepted from an empty FIFO, even with a simultaneous write.
REQ-011 Pointers: read and write pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0; each advances by 1 only on its own accepted operation.
REQ-012 Occupancy: count increments on wr_ok only, decrements on rd_ok only, and is unchanged when both or neither occur; it never exceeds DEPTH or goes below 0.
REQ-013 Flags are combinational decodes of the count register, valid in the same cycle as count:
- full = (count == DEPTH)
- empty = (count == 0)
- almost_full = (count >= AF_LEVEL)
- almost_empty = (count <= AE_LEVEL)
REQ-014 FWFT=0: on rd_ok, data_out loads the head entry at the next edge and data_valid pulses high for exactly that one following cycle; data_out holds its value otherwise.
REQ-015 FWFT=1: data_out continuously presents the head entry and data_valid = !empty; rd_ok pops the entry.
REQ-016 FWFT=1: the first write into an empty FIFO appears on data_out the cycle after that write.
REQ-017 overflow shall set on write_en && !wr_ok and remain set until a cycle with clr_err=1 and no new overflow; set has priority over clear.
REQ-018 underflow shall set on read_en && !rd_ok, with the same hold and clear rules as overflow.
REQ-019 A rejected operation shall not change memory, pointers, count or data_out.

Reset
REQ-020 While reset_n=0 at a rising edge, the block shall clear pointers, count=0, data_out=0, data_valid=0, overflow=0 and underflow=0.
REQ-021 After reset the flags shall read empty=1, full=0, almost_empty=1, and almost_full=0 (given AF_LEVEL >= 1).
REQ-022 Reset mid-operation discards all stored entries; memory contents need not be cleared.
REQ-023 In the cycle reset is asserted, write_en and read_en shall be ignored.

Structure
REQ-024 Package fifo_pkg shall hold the read-mode enum (FIFO_STD, FIFO_FWFT) and default parameter constants.
REQ-025 Storage shall live in sub-module fifo_mem: a DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port.
REQ-026 Pointer, count, flag and error logic shall stay in param_fifo.

Verification
REQ-027 Reset then fill: default parameters, 8 writes of 0x0001..0x0008 with FWFT=0 -> count=8, full=1, almost_full asserted at count=7, overflow=0.
REQ-028 Overflow: one further write while full -> overflow=1, count stays 8, entry 0x0001 intact; a clr_err pulse then clears overflow.
REQ-029 Drain and underflow: 8 reads -> data_out 0x0001..0x0008 in order, each with a one-cycle data_valid pulse one cycle after its read; a 9th read sets underflow=1 and leaves count=0.
REQ-030 Simultaneous full: with the FIFO full, write 0x00AA and read together -> the read returns the head entry, 0x00AA is stored, count stays 8, overflow=0.
REQ-031 Simultaneous empty, wrap: with the FIFO empty, write 0x0055 and read together -> read rejected, underflow=1, count=1; then 20 alternating push/pop cycles wrap the pointers with data kept in order.
REQ-032 FWFT=1, AF_LEVEL=6, AE_LEVEL=2: write 0x1234 -> data_out=0x1234 and data_valid=1 next cycle with no read; almost_full asserts at count=6; reset asserted mid-fill returns count=0, empty=1, data_valid=0.
